// File: rtl/factorial_seq_pkg.sv
// Shared definitions for the sequential math engines: FSM encoding and default widths.
package factorial_seq_pkg;

    localparam int N_W_DEF = 6;
    localparam int Z_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/factorial_seq_fact_mul.sv
// Combinational Z_W x (N_W+1) unsigned multiplier: truncated product plus a flag
// telling whether any bit above the low Z_W was set.
module fact_mul #(
    parameter int N_W = 6,
    parameter int Z_W = 16
) (
    input  logic [Z_W-1:0] i_a,
    input  logic [N_W:0]   i_b,
    output logic [Z_W-1:0] o_lo,
    output logic           o_ovf_bit
);

    logic [Z_W+N_W:0] w_full;

    assign w_full    = {{(N_W+1){1'b0}}, i_a} * {{Z_W{1'b0}}, i_b};
    assign o_lo      = w_full[Z_W-1:0];
    assign o_ovf_bit = |w_full[Z_W+N_W:Z_W];

endmodule

// File: rtl/factorial_seq.sv
// Sequential factorial engine: z = n! with one multiply per clock, start/done handshake,
// busy flag and sticky overflow detection.
module factorial_seq
    import factorial_seq_pkg::*;
#(
    parameter int N_W = N_W_DEF,
    parameter int Z_W = Z_W_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N_W-1:0] n,
    output logic           busy,
    output logic           done,
    output logic [Z_W-1:0] z,
    output logic           ovf,
    output logic [1:0]     dbg_state
);

    // Handshake: start is sampled on each rising edge and accepted only while busy==0
    // (IDLE or DONE); done is a single-cycle pulse marking z/ovf valid, and both stay
    // stable until the next accepted start completes.
    state_t           r_state;
    state_t           w_state_nxt;
    logic [N_W-1:0]   r_n_q;
    logic [N_W:0]     r_cnt;
    logic [Z_W-1:0]   r_acc;
    logic [Z_W-1:0]   r_z;
    logic             r_ovf;
    logic             r_ovf_run;
    logic             r_busy;
    logic             r_done;

    logic             w_accept;
    logic             w_finish;
    logic [Z_W-1:0]   w_prod_lo;
    logic             w_prod_ovf;

    assign w_accept = start && (r_state != ST_CALC);
    assign w_finish = r_cnt > {1'b0, r_n_q};

    fact_mul #(
        .N_W (N_W),
        .Z_W (Z_W)
    ) u_mul (
        .i_a       (r_acc),
        .i_b       (r_cnt),
        .o_lo      (w_prod_lo),
        .o_ovf_bit (w_prod_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_nxt = ST_CALC;
            ST_CALC: if (w_finish) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = start ? ST_CALC : ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Overflow accumulates in r_ovf_run; the visible ovf only moves together with z.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_n_q     <= '0;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_z       <= '0;
            r_ovf     <= 1'b0;
            r_ovf_run <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == ST_CALC) begin
                if (w_finish) begin
                    r_z    <= r_acc;
                    r_ovf  <= r_ovf_run;
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end else begin
                    r_acc     <= w_prod_lo;
                    r_ovf_run <= r_ovf_run | w_prod_ovf;
                    r_cnt     <= r_cnt + 1'b1;
                end
            end else if (w_accept) begin
                r_n_q     <= n;
                r_acc     <= Z_W'(1);
                r_cnt     <= (N_W+1)'(1);
                r_ovf_run <= 1'b0;
                r_busy    <= 1'b1;
            end
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign z         = r_z;
    assign ovf       = r_ovf;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_factorial_seq.sv
// Directed bench for factorial_seq: drivers push expected {ovf,z} into queues, monitors
// pop and compare on every done pulse; latency and busy length are checked by the drivers.
module tb_factorial_seq;

    logic        clk;
    logic        rst_n;
    logic        start_a;
    logic [5:0]  n_a;
    logic        busy_a, done_a, ovf_a;
    logic [15:0] z_a;
    logic [1:0]  st_a;

    logic        start_b;
    logic [3:0]  n_b;
    logic        busy_b, done_b, ovf_b;
    logic [31:0] z_b;
    logic [1:0]  st_b;

    logic [16:0] exp_a_q[$];
    logic [32:0] exp_b_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    factorial_seq #(.N_W(6), .Z_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .n(n_a),
        .busy(busy_a), .done(done_a), .z(z_a), .ovf(ovf_a), .dbg_state(st_a)
    );

    factorial_seq #(.N_W(4), .Z_W(32)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .n(n_b),
        .busy(busy_b), .done(done_b), .z(z_b), .ovf(ovf_b), .dbg_state(st_b)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // monitors
    always @(negedge clk) begin
        if (rst_n && done_a) begin
            if (exp_a_q.size() == 0) begin
                check("a_unexpected_done", 64'd1, 64'd0);
            end else begin
                logic [16:0] e;
                e = exp_a_q.pop_front();
                check("a_z", 64'(z_a), 64'(e[15:0]));
                check("a_ovf", 64'(ovf_a), 64'(e[16]));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && done_b) begin
            if (exp_b_q.size() == 0) begin
                check("b_unexpected_done", 64'd1, 64'd0);
            end else begin
                logic [32:0] e;
                e = exp_b_q.pop_front();
                check("b_z", 64'(z_b), 64'(e[31:0]));
                check("b_ovf", 64'(ovf_b), 64'(e[32]));
            end
        end
    end

    // drivers: called #1 after a rising edge; return #1 after the edge that raised done
    task automatic wait_done_a(input int budget, output int lat, output int busy_cnt);
        lat = 0;
        busy_cnt = busy_a ? 1 : 0;
        while (lat < budget) begin
            @(posedge clk);
            #1;
            lat++;
            if (done_a) break;
            if (busy_a) busy_cnt++;
        end
        if (!done_a) check("a_done_timeout", 64'd0, 64'd1);
    endtask

    task automatic start_a_op(input logic [5:0] nv, input logic [15:0] ez, input logic eo);
        start_a = 1'b1;
        n_a     = nv;
        exp_a_q.push_back({eo, ez});
        @(posedge clk);
        #1;
        start_a = 1'b0;
        n_a     = $urandom_range(0, 63);
    endtask

    task automatic run_a(input logic [5:0] nv, input logic [15:0] ez, input logic eo,
                         input int elat);
        int lat, bc;
        start_a_op(nv, ez, eo);
        wait_done_a(elat + 10, lat, bc);
        check($sformatf("a_lat_n%0d", nv), 64'(lat), 64'(elat));
        check($sformatf("a_busy_n%0d", nv), 64'(bc), 64'(elat));
    endtask

    task automatic run_b(input logic [3:0] nv, input logic [31:0] ez, input logic eo,
                         input int elat);
        int lat;
        start_b = 1'b1;
        n_b     = nv;
        exp_b_q.push_back({eo, ez});
        @(posedge clk);
        #1;
        start_b = 1'b0;
        lat = 0;
        while (lat < elat + 10) begin
            @(posedge clk);
            #1;
            lat++;
            if (done_b) break;
        end
        check($sformatf("b_lat_n%0d", nv), 64'(lat), 64'(elat));
    endtask

    initial begin
        int lat, bc;
        rst_n   = 1'b0;
        start_a = 1'b0;
        n_a     = '0;
        start_b = 1'b0;
        n_b     = '0;
        #22;
        check("rst_busy", 64'(busy_a), 64'd0);
        check("rst_done", 64'(done_a), 64'd0);
        check("rst_z", 64'(z_a), 64'd0);
        check("rst_ovf", 64'(ovf_a), 64'd0);
        check("rst_state", 64'(st_a), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // basic result, latency, busy length and one-cycle done pulse
        run_a(6'd5, 16'd120, 1'b0, 6);
        @(posedge clk);
        #1;
        check("a_done_pulse_width", 64'(done_a), 64'd0);
        check("a_z_held", 64'(z_a), 64'd120);

        run_a(6'd0, 16'd1, 1'b0, 1);
        run_a(6'd1, 16'd1, 1'b0, 2);
        run_a(6'd8, 16'd40320, 1'b0, 9);
        run_a(6'd9, 16'd35200, 1'b1, 10);
        run_a(6'd63, 16'd0, 1'b1, 64);

        // start while busy is ignored
        start_a_op(6'd7, 16'd5040, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        start_a = 1'b1;
        n_a     = 6'd3;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        wait_done_a(30, lat, bc);
        check("a_lat_ignored_start", 64'(lat + 3), 64'd8);
        // back-to-back start in the DONE cycle
        start_a_op(6'd3, 16'd6, 1'b0);
        wait_done_a(20, lat, bc);
        check("a_lat_back_to_back", 64'(lat), 64'd4);

        // asynchronous reset mid-calculation
        repeat (2) @(posedge clk);
        #1;
        start_a = 1'b1;
        n_a     = 6'd20;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        repeat (9) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(busy_a), 64'd0);
        check("arst_done", 64'(done_a), 64'd0);
        check("arst_z", 64'(z_a), 64'd0);
        check("arst_ovf", 64'(ovf_a), 64'd0);
        check("arst_state", 64'(st_a), 64'd0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("arst_q_empty", 64'(exp_a_q.size()), 64'd0);
        run_a(6'd4, 16'd24, 1'b0, 5);

        // wider result instance
        run_b(4'd12, 32'd479001600, 1'b0, 13);
        run_b(4'd13, 32'd1932053504, 1'b1, 14);

        repeat (5) @(posedge clk);
        #1;
        check("final_a_q_empty", 64'(exp_a_q.size()), 64'd0);
        check("final_b_q_empty", 64'(exp_b_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
